// File: rtl/cnn.sv
// Binary-image / binary-kernel 2D convolution engine: one output position per clock,
// all kernels evaluated in parallel against a zero-padded 1-bit image.
module cnn #(
    parameter int IMAGE_WIDTH  = 12,
    parameter int IMAGE_HEIGHT = 12,
    parameter int NUM_FEATURES = 1,
    parameter int KERNEL_SIZE  = 3,
    parameter int STRIDE       = 1,
    localparam int AW = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1
) (
    input  logic                                                         clk,
    input  logic                                                         rst_cnn,
    input  logic                                                         rst_weights,
    input  logic [IMAGE_HEIGHT-1:0][IMAGE_WIDTH-1:0]                     image_input,
    input  logic [KERNEL_SIZE*KERNEL_SIZE-1:0]                           weights_input,
    input  logic [AW-1:0]                                                feature_writeAddr,
    input  logic                                                         feature_WrEn,
    input  logic                                                         convolution_enable,
    output logic [NUM_FEATURES-1:0][IMAGE_HEIGHT-1:0][IMAGE_WIDTH-1:0][31:0] outfmap1
);

    localparam int KK   = KERNEL_SIZE * KERNEL_SIZE;
    localparam int HALF = KERNEL_SIZE / 2;
    localparam int MAXD = (IMAGE_HEIGHT > IMAGE_WIDTH) ? IMAGE_HEIGHT : IMAGE_WIDTH;
    // Position registers must hold pos+STRIDE without overflow for the wrap test.
    localparam int PW   = $clog2(MAXD + STRIDE + 1);

    localparam logic [PW-1:0] STRIDE_V = PW'(STRIDE);
    localparam logic [PW-1:0] WIDTH_V  = PW'(IMAGE_WIDTH);
    localparam logic [PW-1:0] HEIGHT_V = PW'(IMAGE_HEIGHT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [PW-1:0]       row;
    logic [PW-1:0]       col;
    logic [PW-1:0]       row_nxt;
    logic [PW-1:0]       col_nxt;
    logic                col_wrap;
    logic                last_pos;
    logic [KK-1:0]       weights [NUM_FEATURES];
    logic [31:0]         conv_sum [NUM_FEATURES];

    // Correlation (no kernel flip); taps falling outside the image contribute 0.
    function automatic logic [31:0] conv_at(
        input logic [KK-1:0]                         w,
        input logic [IMAGE_HEIGHT-1:0][IMAGE_WIDTH-1:0] img,
        input int                                    r,
        input int                                    c
    );
        logic [31:0] acc;
        int          pr;
        int          pc;
        acc = '0;
        for (int i = 0; i < KERNEL_SIZE; i++) begin
            for (int j = 0; j < KERNEL_SIZE; j++) begin
                pr = r + i - HALF;
                pc = c + j - HALF;
                if (pr >= 0 && pr < IMAGE_HEIGHT && pc >= 0 && pc < IMAGE_WIDTH) begin
                    if (w[i*KERNEL_SIZE+j] && img[pr][pc]) begin
                        acc = acc + 32'd1;
                    end
                end
            end
        end
        return acc;
    endfunction

    always_comb begin
        for (int f = 0; f < NUM_FEATURES; f++) begin
            conv_sum[f] = conv_at(weights[f], image_input, int'(row), int'(col));
        end
    end

    assign col_nxt  = col + STRIDE_V;
    assign row_nxt  = row + STRIDE_V;
    assign col_wrap = (col_nxt >= WIDTH_V);
    assign last_pos = col_wrap && (row_nxt >= HEIGHT_V);

    // Weight memory: slot decode by comparison so out-of-range addresses match nothing.
    always_ff @(posedge clk) begin
        if (rst_weights) begin
            for (int f = 0; f < NUM_FEATURES; f++) begin
                weights[f] <= '0;
            end
        end else if (!feature_WrEn) begin
            for (int f = 0; f < NUM_FEATURES; f++) begin
                if (feature_writeAddr == AW'(f)) begin
                    weights[f] <= weights_input;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_cnn) begin
            state    <= IDLE;
            row      <= '0;
            col      <= '0;
            outfmap1 <= '0;
        end else begin
            case (state)
                IDLE, RUN: begin
                    if (!convolution_enable) begin
                        for (int f = 0; f < NUM_FEATURES; f++) begin
                            outfmap1[f][row][col] <= conv_sum[f];
                        end
                        if (last_pos) begin
                            state <= DONE;
                        end else begin
                            state <= RUN;
                            if (col_wrap) begin
                                col <= '0;
                                row <= row_nxt;
                            end else begin
                                col <= col_nxt;
                            end
                        end
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnn.sv
// Directed bench for cnn: three kernel slots, hand-derived expected maps.
module tb_cnn;

    localparam int W  = 12;
    localparam int H  = 12;
    localparam int NF = 3;
    localparam int K  = 3;

    logic                                clk;
    logic                                rst_cnn;
    logic                                rst_weights;
    logic [H-1:0][W-1:0]                 image_input;
    logic [K*K-1:0]                      weights_input;
    logic [1:0]                          feature_writeAddr;
    logic                                feature_WrEn;
    logic                                convolution_enable;
    logic [NF-1:0][H-1:0][W-1:0][31:0]   outfmap1;

    int n_err = 0;
    int n_chk = 0;

    cnn #(
        .IMAGE_WIDTH (W),
        .IMAGE_HEIGHT(H),
        .NUM_FEATURES(NF),
        .KERNEL_SIZE (K),
        .STRIDE      (1)
    ) dut (
        .clk               (clk),
        .rst_cnn           (rst_cnn),
        .rst_weights       (rst_weights),
        .image_input       (image_input),
        .weights_input     (weights_input),
        .feature_writeAddr (feature_writeAddr),
        .feature_WrEn      (feature_WrEn),
        .convolution_enable(convolution_enable),
        .outfmap1          (outfmap1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        convolution_enable = 1'b0;
        tick(n);
        convolution_enable = 1'b1;
    endtask

    task automatic wr(input logic [1:0] addr, input logic [K*K-1:0] w);
        feature_writeAddr = addr;
        weights_input     = w;
        feature_WrEn      = 1'b0;
        tick(1);
        feature_WrEn      = 1'b1;
    endtask

    task automatic pulse_rst();
        rst_cnn = 1'b1;
        tick(1);
        rst_cnn = 1'b0;
    endtask

    // Kinds: 0 zero, 1 X kernel on ones, 2 top-left tap on ones, 3 centre tap on ones,
    // 4 X kernel on pixel(5,5), 5 top-left tap on pixel(5,5), 6 centre tap on pixel(5,5)
    function automatic logic [31:0] expect_at(input int kind, input int r, input int c);
        logic er, ec;
        er = (r == 0) || (r == H - 1);
        ec = (c == 0) || (c == W - 1);
        case (kind)
            1: return (er && ec) ? 32'd2 : ((er || ec) ? 32'd3 : 32'd5);
            2: return (r >= 1 && c >= 1) ? 32'd1 : 32'd0;
            3: return 32'd1;
            4: return ((r == 5 && c == 5) || ((r == 4 || r == 6) && (c == 4 || c == 6))) ? 32'd1 : 32'd0;
            5: return (r == 6 && c == 6) ? 32'd1 : 32'd0;
            6: return (r == 5 && c == 5) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check_map(input string tag, input int f, input int kind);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                chk($sformatf("%s_f%0d[%0d][%0d]", tag, f, r, c), outfmap1[f][r][c], expect_at(kind, r, c));
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int f = 0; f < NF; f++) check_map(tag, f, 0);
    endtask

    function automatic logic [31:0] map_sum(input int f);
        logic [31:0] s;
        s = '0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                s = s + outfmap1[f][r][c];
        return s;
    endfunction

    initial begin
        rst_cnn            = 1'b1;
        rst_weights        = 1'b1;
        image_input        = '0;
        weights_input      = '0;
        feature_writeAddr  = '0;
        feature_WrEn       = 1'b1;
        convolution_enable = 1'b1;
        tick(2);
        rst_cnn     = 1'b0;
        rst_weights = 1'b0;
        check_all_zero("reset");

        // Slot 0: X kernel, slot 1: top-left tap only, slot 2: centre tap only
        wr(2'd0, 9'h155);
        wr(2'd1, 9'h001);
        wr(2'd2, 9'h010);
        image_input = '1;

        run(143);
        chk("lat143_11_11", outfmap1[0][11][11], 32'd0);
        chk("lat143_11_10", outfmap1[0][11][10], 32'd3);
        run(1);
        chk("lat144_11_11", outfmap1[0][11][11], 32'd2);
        check_map("ones", 0, 1);
        check_map("ones", 1, 2);
        check_map("ones", 2, 3);

        run(20);
        chk("done_hold_11_11", outfmap1[0][11][11], 32'd2);
        chk("done_sum_f0", map_sum(0), 32'd628);
        chk("done_sum_f1", map_sum(1), 32'd121);
        chk("done_sum_f2", map_sum(2), 32'd144);

        // Out-of-range slot write must not disturb any kernel
        wr(2'd3, 9'h1FF);
        pulse_rst();
        run(20);
        chk("mid_1_7", outfmap1[0][1][7], 32'd5);
        chk("mid_1_8", outfmap1[0][1][8], 32'd0);
        pulse_rst();
        check_all_zero("midrst");

        run(50);
        convolution_enable = 1'b1;
        tick(5);
        chk("pause_4_1", outfmap1[0][4][1], 32'd5);
        chk("pause_4_2", outfmap1[0][4][2], 32'd0);
        run(94);
        check_map("rerun", 0, 1);
        check_map("rerun", 1, 2);
        check_map("rerun", 2, 3);

        pulse_rst();
        image_input = '0;
        run(144);
        check_all_zero("zeroimg");

        pulse_rst();
        image_input       = '0;
        image_input[5][5] = 1'b1;
        run(144);
        check_map("pixel", 0, 4);
        check_map("pixel", 1, 5);
        check_map("pixel", 2, 6);

        // Both resets together: maps and kernels cleared
        rst_cnn     = 1'b1;
        rst_weights = 1'b1;
        tick(1);
        rst_cnn     = 1'b0;
        rst_weights = 1'b0;
        image_input = '1;
        run(144);
        check_all_zero("noweights");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
